// File: rtl/asip_mem_pkg.sv
// asip_mem_pkg
// Shared types and constants for the data-memory arbitration slice.
//   arb_state_t : arbiter FSM states (IDLE, BURST)
//   owner_t     : tag naming the requester that owns the read currently
//                 returning from data_mem
//   WORD_BYTES  : byte stride between consecutive burst beats
package asip_mem_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DISP = 2'd2
    } owner_t;

endpackage

// File: rtl/dmem_burst_counter.sv
// dmem_burst_counter
// Address generator for a fixed-length display read burst.
// Ports:
//   clk, reset  : system clock, asynchronous active-low reset
//   start       : burst granted this cycle (beat 0 issued by the arbiter)
//   start_addr  : burst base byte address, captured on start
//   advance     : a beat from beat_addr is being issued this cycle
//   beat_addr   : base + WORD_BYTES*beat, wrapping modulo 2^N
//   last_beat   : current beat is the final one (BURST-1)
module dmem_burst_counter
    import asip_mem_pkg::*;
#(
    parameter int N     = 32,
    parameter int BURST = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] start_addr,
    input  logic         advance,
    output logic [N-1:0] beat_addr,
    output logic         last_beat
);

    localparam int BW = (BURST > 2) ? $clog2(BURST) : 1;

    logic [N-1:0]  base_addr;
    logic [BW-1:0] beat;

    // Beat 0 goes out directly from the arbiter on grant, so the counter
    // starts at 1 and returns to 0 once the final beat has been issued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_addr <= '0;
            beat      <= '0;
        end else if (start) begin
            base_addr <= start_addr;
            beat      <= BW'(1);
        end else if (advance) begin
            beat      <= last_beat ? '0 : beat + 1'b1;
        end
    end

    assign beat_addr = base_addr + N'(beat) * N'(WORD_BYTES);
    assign last_beat = (beat == BW'(BURST - 1));

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single data_mem port between the processor (single loads and
// stores) and the display pixel fetch (fixed-length read bursts). Display
// has priority; a starvation counter forces a CPU win after MAX_WAIT denied
// request cycles.
// Ports:
//   clk, reset              : system clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata   : CPU access request (held until cpu_gnt)
//   cpu_gnt                 : CPU access issued this cycle
//   cpu_rvalid/cpu_rdata    : load data, one cycle after a load grant
//   disp_req/disp_addr      : display burst request and base address
//   disp_gnt                : burst accepted, beat 0 issued this cycle
//   disp_rvalid/rdata/last  : burst beat data, last marks final beat
//   mem_addr/we/wdata       : data_mem request port
//   mem_rdata               : data_mem read data, one cycle after mem_addr
module dmem_arbiter
    import asip_mem_pkg::*;
#(
    parameter int N        = 32,
    parameter int BURST    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cpu_req,
    input  logic         cpu_we,
    input  logic [N-1:0] cpu_addr,
    input  logic [N-1:0] cpu_wdata,
    output logic         cpu_gnt,
    output logic         cpu_rvalid,
    output logic [N-1:0] cpu_rdata,
    input  logic         disp_req,
    input  logic [N-1:0] disp_addr,
    output logic         disp_gnt,
    output logic         disp_rvalid,
    output logic [N-1:0] disp_rdata,
    output logic         disp_last,
    output logic [N-1:0] mem_addr,
    output logic         mem_we,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata
);

    localparam int WW = $clog2(MAX_WAIT + 1);

    arb_state_t    state_q, state_d;
    logic [WW-1:0] wait_cnt;
    owner_t        rd_owner, owner_d;
    logic          rd_last;
    logic          disp_issue;
    logic [N-1:0]  beat_addr;
    logic          beat_last;

    dmem_burst_counter #(
        .N     (N),
        .BURST (BURST)
    ) u_burst_counter (
        .clk        (clk),
        .reset      (reset),
        .start      (disp_gnt),
        .start_addr (disp_addr),
        .advance    (state_q == asip_mem_pkg::BURST),
        .beat_addr  (beat_addr),
        .last_beat  (beat_last)
    );

    // Arbitration and memory request mux. Everything is forced to zero while
    // reset is held, so a grant cannot leak out combinationally from a
    // request that happens to be present during reset.
    always_comb begin
        state_d    = state_q;
        cpu_gnt    = 1'b0;
        disp_gnt   = 1'b0;
        disp_issue = 1'b0;
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        owner_d    = OWN_NONE;
        if (reset) begin
            case (state_q)
                asip_mem_pkg::IDLE: begin
                    if (disp_req && (wait_cnt < WW'(MAX_WAIT) || !cpu_req)) begin
                        disp_gnt   = 1'b1;
                        disp_issue = 1'b1;
                        mem_addr   = disp_addr;
                        state_d    = asip_mem_pkg::BURST;
                    end else if (cpu_req) begin
                        cpu_gnt   = 1'b1;
                        mem_addr  = cpu_addr;
                        mem_we    = cpu_we;
                        mem_wdata = cpu_wdata;
                    end
                end
                asip_mem_pkg::BURST: begin
                    disp_issue = 1'b1;
                    mem_addr   = beat_addr;
                    if (beat_last) begin
                        state_d = asip_mem_pkg::IDLE;
                    end
                end
                default: state_d = asip_mem_pkg::IDLE;
            endcase
        end
        if (cpu_gnt && !cpu_we) begin
            owner_d = OWN_CPU;
        end else if (disp_issue) begin
            owner_d = OWN_DISP;
        end
    end

    // FSM state plus the one-cycle read tag; clearing the tag on reset is
    // what discards a read that was in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= asip_mem_pkg::IDLE;
            rd_owner <= OWN_NONE;
            rd_last  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_owner <= owner_d;
            rd_last  <= disp_issue && (state_q == asip_mem_pkg::BURST) && beat_last;
        end
    end

    // Starvation counter: counts denied CPU request cycles, saturates at
    // MAX_WAIT, holds while the CPU is not requesting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (cpu_gnt) begin
            wait_cnt <= '0;
        end else if (cpu_req && wait_cnt != WW'(MAX_WAIT)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign cpu_rvalid  = (rd_owner == OWN_CPU);
    assign disp_rvalid = (rd_owner == OWN_DISP);
    assign disp_last   = disp_rvalid && rd_last;
    assign cpu_rdata   = mem_rdata;
    assign disp_rdata  = mem_rdata;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: the processor (single load/store accesses) and the display pixel-fetch path (fixed-length read bursts).
- Sits between processor/display fetch and data_mem.
- Display has priority, because scan-out is real-time.
- A starvation counter guarantees the processor a grant within bounded time.

Parameters:
N, 32, data and address width in bits
BURST, 4, words per display burst (>=2)
MAX_WAIT, 8, consecutive denied CPU-request cycles after which the CPU wins the next arbitration

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cpu_req  in  1  CPU access request, held until cpu_gnt
cpu_we  in  1  1 = store, 0 = load
cpu_addr  in  N  CPU byte address
cpu_wdata  in  N  store data
cpu_gnt  out  1  access accepted this cycle
cpu_rvalid  out  1  load data valid (1 cycle after grant of a load)
cpu_rdata  out  N  load data
disp_req  in  1  burst request, held until disp_gnt
disp_addr  in  N  burst base byte address
disp_gnt  out  1  burst accepted, beat 0 issued this cycle
disp_rvalid  out  1  burst beat data valid
disp_rdata  out  N  burst beat data
disp_last  out  1  with disp_rvalid: final beat
mem_addr  out  N  memory address
mem_we  out  1  memory write strobe
mem_wdata  out  N  memory write data
mem_rdata  in  N  memory read data, valid 1 cycle after mem_addr

Behaviour:
- Reset (reset=0, async): state IDLE, beat counter 0, wait_cnt 0, all rvalid/last/gnt/we outputs 0, mem_addr and mem_wdata 0; any in-flight read is discarded.
- FSM states: IDLE, BURST.
- IDLE arbitration (combinational, same cycle):
  - if disp_req and (wait_cnt<MAX_WAIT or !cpu_req): disp_gnt=1, mem_addr=disp_addr, go BURST with beat=1.
  - else if cpu_req: cpu_gnt=1, mem_addr=cpu_addr, mem_we=cpu_we, mem_wdata=cpu_wdata; stay IDLE.
  - else mem_addr=0, mem_we=0.
- BURST:
  - Each cycle mem_addr = base + 4*beat (mod 2^N; wrap past 2^N-1 is legal).
  - beat increments.
  - After issuing beat BURST-1, return to IDLE; arbitration resumes the following cycle.
  - Burst is non-interruptible; no grant is issued during BURST.
- Read return: one-cycle registered tag of the owner of each read.
  - Cycle after a CPU load grant: cpu_rvalid=1, cpu_rdata=mem_rdata.
  - Cycle after each burst beat: disp_rvalid=1, disp_rdata=mem_rdata.
  - disp_last=1 on the beat BURST-1 return only.
  - Stores produce no rvalid.
  - rdata outputs are passthrough of mem_rdata; consumers sample only on rvalid.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) each cycle cpu_req=1 and cpu_gnt=0.
  - Clears on cpu_gnt.
  - Holds when cpu_req=0.
- Simultaneous requests in IDLE with wait_cnt<MAX_WAIT: display wins. With wait_cnt==MAX_WAIT: CPU wins, display waits at least one cycle.
- Maximum CPU latency from request: MAX_WAIT + BURST cycles.
- A requester dropping req before gnt is a protocol violation (not checked).
- Reset asserted mid-burst: remaining beats are not issued, no disp_last; after release the display must re-request.

Decomposition:
- Package asip_mem_pkg:
  - arb_state_t enum {IDLE, BURST}
  - WORD_BYTES=4
  - owner_t enum {OWN_NONE, OWN_CPU, OWN_DISP} for the read tag
- One sub-module: dmem_burst_counter. It holds the base address register, the beat counter and the address adder, and outputs beat address and last-beat flag.

Test Plan:
- CPU only: load addr 0x100 (mem holds 0xDEADBEEF) -> cpu_gnt same cycle, cpu_rvalid with 0xDEADBEEF next cycle; store 0x104/0x12345678 -> mem_we one cycle, no cpu_rvalid.
- Display only, BURST=4, base 0x2000 -> mem_addr 0x2000,0x2004,0x2008,0x200C on 4 consecutive cycles; 4 disp_rvalid one cycle later; disp_last on 4th only.
- Both request in IDLE, wait_cnt=0 -> display granted; CPU granted the cycle after burst beat 3 (if disp_req dropped); cpu_rvalid correct, no disp_rvalid on that cycle.
- Continuous disp_req plus CPU load, MAX_WAIT=8 -> CPU granted by cycle 12 at latest after cpu_req rises; wait_cnt back to 0.
- Burst base 0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
- reset pulsed low during beat 2 -> all outputs 0 asynchronously, no further beats/rvalid; a new disp_req after release starts at beat 0.
